// File: rtl/game_state_uart_tx_pkg.sv
// Shared constants, packet FSM encoding and packet builder for the game-state UART link.
package game_state_uart_tx_pkg;

  localparam logic [7:0]  PKT_SYNC  = 8'hA5;
  localparam int unsigned PKT_BYTES = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } pkt_state_e;

  // Byte 0 sits in bits [7:0]; byte 7 (xor of bytes 1..6) in bits [63:56].
  function automatic logic [63:0] build_packet(
    input logic [1:0]  game_state,
    input logic [10:0] x_ball,
    input logic [9:0]  y_ball,
    input logic [9:0]  y_player_1,
    input logic [3:0]  player1_score,
    input logic [3:0]  player2_score
  );
    logic [7:0] b1, b2, b3, b4, b5, b6, b7;
    b1 = {3'b000, game_state, x_ball[10:8]};
    b2 = x_ball[7:0];
    b3 = {4'b0000, y_ball[9:8], y_player_1[9:8]};
    b4 = y_ball[7:0];
    b5 = y_player_1[7:0];
    b6 = {player1_score, player2_score};
    b7 = b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6;
    return {b7, b6, b5, b4, b3, b2, b1, PKT_SYNC};
  endfunction

  function automatic logic [7:0] pkt_byte(input logic [63:0] pkt, input logic [2:0] idx);
    return pkt[{idx, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser; accepts a new byte in the final cycle of the stop bit for gapless streams.
module uart_tx_byte #(
  parameter int unsigned CLK_HZ = 65_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       ready,
  output logic       done
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       bit_q, bit_d;
  logic [8:0]       shift_q, shift_d;
  logic             tx_q, tx_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign done    = active_q && bit_end && (bit_q == 4'd9);
  assign ready   = !active_q || done;
  assign tx      = tx_q;

  // bit_q: 0 = start, 1..8 = data LSB first, 9 = stop; shift_q holds the bits still to go out.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (start && ready) begin
      active_d = 1'b1;
      cnt_d    = '0;
      bit_d    = '0;
      shift_d  = {1'b1, data};
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        cnt_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d   = bit_q + 4'd1;
          tx_d    = shift_q[0];
          shift_d = {1'b1, shift_q[8:1]};
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/game_state_uart_tx.sv
// Snapshots the pong game state on each frame tick and streams it as an 8-byte UART packet.
module game_state_uart_tx
  import game_state_uart_tx_pkg::*;
#(
  parameter int unsigned CLK_HZ = 65_000_000,
  parameter int unsigned BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic [10:0] x_ball,
  input  logic [9:0]  y_ball,
  input  logic [9:0]  y_player_1,
  input  logic [1:0]  state,
  input  logic [3:0]  player1_score,
  input  logic [3:0]  player2_score,
  output logic        tx,
  output logic        busy,
  output logic        pkt_done
);

  localparam logic [2:0] LAST_IDX = 3'(PKT_BYTES - 1);

  pkt_state_e  fsm_q, fsm_d;
  logic [2:0]  idx_q, idx_d;
  logic [63:0] pkt_q, pkt_d;
  logic        ser_start, ser_ready, ser_done;
  logic [7:0]  ser_data;

  assign busy     = (fsm_q == S_SEND) || (fsm_q == S_WAIT);
  assign pkt_done = (fsm_q == S_DONE);

  always_comb begin
    fsm_d     = fsm_q;
    idx_d     = idx_q;
    pkt_d     = pkt_q;
    ser_start = 1'b0;
    ser_data  = pkt_byte(pkt_q, idx_q);
    case (fsm_q)
      S_IDLE, S_DONE: begin
        fsm_d = S_IDLE;
        if (timing_tick) begin
          pkt_d = build_packet(state, x_ball, y_ball, y_player_1,
                               player1_score, player2_score);
          idx_d = '0;
          fsm_d = S_SEND;
        end
      end
      S_SEND: begin
        if (ser_ready) begin
          ser_start = 1'b1;
          fsm_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // Later bytes are handed over on the done cycle itself rather than via S_SEND,
        // so the next start bit directly follows the previous stop bit.
        if (ser_done) begin
          if (idx_q == LAST_IDX) begin
            fsm_d = S_DONE;
          end else begin
            idx_d     = idx_q + 3'd1;
            ser_start = 1'b1;
            ser_data  = pkt_byte(pkt_q, idx_d);
          end
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q <= S_IDLE;
      idx_q <= '0;
      pkt_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      idx_q <= idx_d;
      pkt_q <= pkt_d;
    end
  end

  uart_tx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .start (ser_start),
    .data  (ser_data),
    .tx    (tx),
    .ready (ser_ready),
    .done  (ser_done)
  );

endmodule

// File: tb/tb_game_state_uart_tx.sv
// Bench for game_state_uart_tx: bit-stream model, UART decoder and directed packet scenarios.
module tb_game_state_uart_tx;

  localparam int unsigned CLK_HZ  = 1000;
  localparam int unsigned BAUD    = 100;
  localparam int unsigned C       = CLK_HZ / BAUD;
  localparam int unsigned PKT_CYC = 80 * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        timing_tick = 1'b0;
  logic [10:0] x_ball = '0;
  logic [9:0]  y_ball = '0;
  logic [9:0]  y_player_1 = '0;
  logic [1:0]  state = '0;
  logic [3:0]  player1_score = '0;
  logic [3:0]  player2_score = '0;
  logic        tx, busy, pkt_done;

  always #5 clk = ~clk;

  game_state_uart_tx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .timing_tick   (timing_tick),
    .x_ball        (x_ball),
    .y_ball        (y_ball),
    .y_player_1    (y_player_1),
    .state         (state),
    .player1_score (player1_score),
    .player2_score (player2_score),
    .tx            (tx),
    .busy          (busy),
    .pkt_done      (pkt_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Packet as the wire format defines it: byte k in bits [8k+7:8k].
  function automatic logic [63:0] pkt64(input logic [1:0] st, input logic [10:0] x,
                                        input logic [9:0] y, input logic [9:0] yp,
                                        input logic [3:0] s1, input logic [3:0] s2);
    logic [7:0] by [8];
    logic [63:0] r;
    by[0] = 8'hA5;
    by[1] = {3'b000, st, x[10:8]};
    by[2] = x[7:0];
    by[3] = {4'b0000, y[9:8], yp[9:8]};
    by[4] = y[7:0];
    by[5] = yp[7:0];
    by[6] = {s1, s2};
    by[7] = 8'h00;
    for (int k = 1; k <= 6; k++) by[7] = by[7] ^ by[k];
    for (int k = 0; k < 8; k++) r[k*8 +: 8] = by[k];
    return r;
  endfunction

  // Reference: after an accepted tick, line time t (1..80*C) carries bit (t-1)/C of the frame stream.
  bit          m_active = 1'b0;
  int          m_t = 0;
  bit          m_bits [80];
  logic        m_tx = 1'b1, m_busy = 1'b0, m_done = 1'b0;
  logic [63:0] m_pkt;

  initial forever begin
    @(posedge clk);
    m_done = 1'b0;
    if (rst) begin
      m_active = 1'b0;
    end else if (!m_active && timing_tick) begin
      m_active = 1'b1;
      m_t = 0;
      m_pkt = pkt64(state, x_ball, y_ball, y_player_1, player1_score, player2_score);
      for (int k = 0; k < 8; k++) begin
        m_bits[k*10] = 1'b0;
        for (int j = 0; j < 8; j++) m_bits[k*10+1+j] = m_pkt[k*8+j];
        m_bits[k*10+9] = 1'b1;
      end
    end else if (m_active) begin
      m_t++;
      if (m_t == int'(PKT_CYC) + 1) begin
        m_active = 1'b0;
        m_done = 1'b1;
      end
    end
    m_busy = m_active;
    m_tx = (m_active && m_t >= 1) ? m_bits[(m_t-1)/int'(C)] : 1'b1;
  end

  bit cmp_en = 1'b0;
  int done_cnt = 0;

  initial forever begin
    @(negedge clk);
    if (pkt_done === 1'b1) done_cnt++;
    if (cmp_en) begin
      chk("tx_vs_model", {31'd0, tx}, {31'd0, m_tx});
      chk("busy_vs_model", {31'd0, busy}, {31'd0, m_busy});
      chk("pkt_done_vs_model", {31'd0, pkt_done}, {31'd0, m_done});
    end
  end

  // Line decoder: samples mid-bit, counting from the first low cycle of each start bit.
  logic [7:0] rx_q [$];
  bit         rx_on = 1'b0;
  int         rx_c = 0;
  logic [7:0] rx_sh = '0;

  initial forever begin
    @(negedge clk);
    if (rst) begin
      rx_on = 1'b0;
    end else if (!rx_on) begin
      if (tx === 1'b0) begin
        rx_on = 1'b1;
        rx_c = 0;
      end
    end else begin
      rx_c++;
      if (rx_c % int'(C) == int'(C) / 2) begin
        if (rx_c / int'(C) == 0) begin
          chk("rx_start_bit", {31'd0, tx}, 32'd0);
        end else if (rx_c / int'(C) <= 8) begin
          rx_sh[rx_c/int'(C) - 1] = tx;
        end else begin
          chk("rx_stop_bit", {31'd0, tx}, 32'd1);
          rx_q.push_back(rx_sh);
          rx_on = 1'b0;
        end
      end
    end
  end

  task automatic set_in(input logic [1:0] st, input logic [10:0] x, input logic [9:0] y,
                        input logic [9:0] yp, input logic [3:0] s1, input logic [3:0] s2);
    state = st; x_ball = x; y_ball = y; y_player_1 = yp;
    player1_score = s1; player2_score = s2;
  endtask

  task automatic pulse_tick();
    @(negedge clk);
    timing_tick = 1'b1;
    @(negedge clk);
    timing_tick = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc, output int bcnt);
    bit got;
    got = 1'b0;
    bcnt = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (pkt_done === 1'b1) got = 1'b1;
      else if (busy === 1'b1) bcnt++;
    end
    chk({name, "_done_seen"}, {31'd0, got}, 32'd1);
  endtask

  task automatic chk_rx(input string name, input logic [63:0] exp);
    logic [31:0] got;
    for (int k = 0; k < 8; k++) begin
      got = (rx_q.size() > 0) ? {24'd0, rx_q.pop_front()} : 32'hFFFF_FFFF;
      chk($sformatf("%s_B%0d", name, k), got, {24'd0, exp[k*8 +: 8]});
    end
  endtask

  initial begin
    int b0, bc, d0, low;
    logic [63:0] e1, e2;

    // Reset
    repeat (5) @(negedge clk);
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_pkt_done", {31'd0, pkt_done}, 32'd0);
    rst = 1'b0;
    cmp_en = 1'b1;
    low = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1) low++;
    end
    chk("idle_tx_low_cycles", low, 0);

    // Single packet
    set_in(2'b01, 11'd677, 10'd384, 10'd300, 4'd3, 4'd2);
    d0 = done_cnt;
    pulse_tick();
    chk("accept_busy", {31'd0, busy}, 32'd1);
    chk("accept_tx_high", {31'd0, tx}, 32'd1);
    @(negedge clk);
    chk("first_start_bit", {31'd0, tx}, 32'd0);
    b0 = (busy === 1'b1) ? 1 : 0;
    wait_done("single", 2000, bc);
    chk("single_busy_cycles_after_accept", b0 + bc, PKT_CYC);
    repeat (20) @(negedge clk);
    chk("single_done_pulses", done_cnt - d0, 1);
    chk("single_rx_count", rx_q.size(), 8);
    chk_rx("single", 64'h3432_2C80_05A5_0AA5);

    // Ticks while busy, inputs changing mid-packet
    set_in(2'b10, 11'd1234, 10'd567, 10'd89, 4'd7, 4'd9);
    e1 = pkt64(2'b10, 11'd1234, 10'd567, 10'd89, 4'd7, 4'd9);
    d0 = done_cnt;
    pulse_tick();
    repeat (98) @(negedge clk);
    set_in(2'b00, 11'd5, 10'd6, 10'd7, 4'd1, 4'd1);
    pulse_tick();
    repeat (398) @(negedge clk);
    set_in(2'b11, 11'd2000, 10'd1000, 10'd999, 4'd14, 4'd13);
    pulse_tick();
    wait_done("ignored", 2000, bc);
    repeat (200) @(negedge clk);
    chk("ignored_done_pulses", done_cnt - d0, 1);
    chk("ignored_busy_after", {31'd0, busy}, 32'd0);
    chk("ignored_rx_count", rx_q.size(), 8);
    chk_rx("ignored", e1);

    // Back-to-back: tick during the pkt_done cycle
    set_in(2'b00, 11'd100, 10'd200, 10'd300, 4'd5, 4'd0);
    e1 = pkt64(2'b00, 11'd100, 10'd200, 10'd300, 4'd5, 4'd0);
    d0 = done_cnt;
    pulse_tick();
    wait_done("b2b_first", 2000, bc);
    set_in(2'b01, 11'd1537, 10'd770, 10'd515, 4'd9, 4'd6);
    e2 = pkt64(2'b01, 11'd1537, 10'd770, 10'd515, 4'd9, 4'd6);
    timing_tick = 1'b1;
    @(negedge clk);
    timing_tick = 1'b0;
    chk("b2b_accept_busy", {31'd0, busy}, 32'd1);
    chk("b2b_pkt_done_cleared", {31'd0, pkt_done}, 32'd0);
    @(negedge clk);
    chk("b2b_start_no_idle_bit", {31'd0, tx}, 32'd0);
    wait_done("b2b_second", 2000, bc);
    repeat (20) @(negedge clk);
    chk("b2b_done_pulses", done_cnt - d0, 2);
    chk("b2b_rx_count", rx_q.size(), 16);
    chk_rx("b2b_first", e1);
    chk_rx("b2b_second", e2);

    // Reset in the middle of a packet
    set_in(2'b01, 11'd42, 10'd43, 10'd44, 4'd2, 4'd3);
    d0 = done_cnt;
    pulse_tick();
    repeat (349) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_tx", {31'd0, tx}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_pkt_done", {31'd0, pkt_done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (900) @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    rx_q.delete();
    set_in(2'b10, 11'd300, 10'd600, 10'd900, 4'd11, 4'd4);
    e1 = pkt64(2'b10, 11'd300, 10'd600, 10'd900, 4'd11, 4'd4);
    pulse_tick();
    wait_done("after_rst", 2000, bc);
    repeat (20) @(negedge clk);
    chk("after_rst_rx_count", rx_q.size(), 8);
    chk_rx("after_rst", e1);

    // Boundary values
    set_in(2'b11, 11'd2047, 10'd1023, 10'd1023, 4'd15, 4'd15);
    pulse_tick();
    wait_done("boundary", 2000, bc);
    repeat (20) @(negedge clk);
    chk("boundary_rx_count", rx_q.size(), 8);
    chk_rx("boundary", 64'h10FF_FFFF_0FFF_1FA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
